// File: rtl/reg_dump_ctrl_pkg.sv
// Shared MIPS debug package: dump FSM state encoding and register/byte sizing helpers.
package reg_dump_ctrl_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_CAPT = 3'd2;
    localparam logic [2:0] ST_SEND = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam int REG_SIZE      = 32;
    localparam int BYTES_PER_REG = REG_SIZE / 8;

    function automatic int bytes_per_reg(input int size);
        return size / 8;
    endfunction

    // Counter width that stays legal when only one byte per register exists.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_dump_ctrl_if.sv
// Register-bank read port plus byte stream towards the serial transmitter.
interface reg_dump_ctrl_if #(
    parameter int SIZE         = 32,
    parameter int SIZE_REG_DIR = 5
);
    logic [SIZE_REG_DIR-1:0] o_rd_dir;
    logic [SIZE-1:0]         i_rd_data;
    logic [7:0]              o_byte;
    logic                    o_byte_valid;
    logic                    i_byte_ready;

    modport master (
        output o_rd_dir, o_byte, o_byte_valid,
        input  i_rd_data, i_byte_ready
    );

    modport slave (
        input  o_rd_dir, o_byte, o_byte_valid,
        output i_rd_data, i_byte_ready
    );
endinterface

// File: rtl/reg_dump_ctrl.sv
// Dumps the whole register file, MSB-first, one byte at a time through a
// valid/ready stream while the pipeline is halted.
module reg_dump_ctrl
    import reg_dump_ctrl_pkg::*;
#(
    parameter int SIZE          = 32,
    parameter int NUM_REGISTERS = 32,
    parameter int SIZE_REG_DIR  = $clog2(NUM_REGISTERS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic                  i_halted,
    reg_dump_ctrl_if.master       bus,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam int BPR   = bytes_per_reg(SIZE);
    localparam int CNT_W = cnt_width(BPR);

    localparam logic [CNT_W-1:0]        LAST_BYTE = CNT_W'(BPR - 1);
    localparam logic [SIZE_REG_DIR-1:0] LAST_REG  = SIZE_REG_DIR'(NUM_REGISTERS - 1);

    logic [2:0]              r_state;
    logic [SIZE_REG_DIR-1:0] r_index;
    logic [CNT_W-1:0]        r_byte_cnt;
    logic [SIZE-1:0]         r_shift;
    logic                    r_err;

    logic w_send;
    logic w_in_dump;
    logic w_last_byte;
    logic w_last_reg;

    assign w_send      = (r_state == ST_SEND);
    assign w_in_dump   = (r_state == ST_ADDR) || (r_state == ST_CAPT) || w_send;
    assign w_last_byte = (r_byte_cnt == LAST_BYTE);
    assign w_last_reg  = (r_index == LAST_REG);

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_index    <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            // Abort outranks everything, including a transfer in the same cycle.
            if (i_abort) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            if (i_halted) begin
                                r_index <= '0;
                                r_state <= ST_ADDR;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    // One cycle of address setup covers the bank's negedge read.
                    ST_ADDR: r_state <= ST_CAPT;
                    ST_CAPT: begin
                        r_shift    <= bus.i_rd_data;
                        r_byte_cnt <= '0;
                        r_state    <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (bus.i_byte_ready) begin
                            r_shift <= r_shift << 8;
                            if (!w_last_byte) begin
                                r_byte_cnt <= r_byte_cnt + 1'b1;
                            end else if (!w_last_reg) begin
                                r_index <= r_index + 1'b1;
                                r_state <= ST_ADDR;
                            end else begin
                                r_state <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.o_rd_dir     = w_in_dump ? r_index : '0;
    assign bus.o_byte_valid = w_send;
    assign bus.o_byte       = w_send ? r_shift[SIZE-1 -: 8] : 8'h00;

    assign o_busy = (r_state != ST_IDLE);
    assign o_done = (r_state == ST_DONE);
    assign o_err  = r_err;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Self-checking bench for reg_dump_ctrl: vector table, directed corner cases and
// randomized dumps compared against a byte-stream model of the register file.
module tb_reg_dump_ctrl;

    localparam int SIZE  = 32;
    localparam int NUM   = 32;
    localparam int DIRW  = 5;
    localparam int BPR   = SIZE / 8;
    localparam int TOTAL = NUM * BPR;
    localparam int LAT   = NUM * (2 + BPR);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic i_start;
    logic i_abort;
    logic i_halted;
    logic o_busy;
    logic o_done;
    logic o_err;

    reg_dump_ctrl_if #(.SIZE(SIZE), .SIZE_REG_DIR(DIRW)) bus ();

    reg_dump_ctrl #(
        .SIZE          (SIZE),
        .NUM_REGISTERS (NUM),
        .SIZE_REG_DIR  (DIRW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (i_start),
        .i_abort  (i_abort),
        .i_halted (i_halted),
        .bus      (bus),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_err    (o_err)
    );

    int n_tests;
    int n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Register bank with a negedge-registered read port.
    logic [31:0] bank [NUM];
    always @(negedge clk) bus.i_rd_data <= bank[bus.o_rd_dir];

    // Ready generator: 0 = always ready, 1 = repeating 1-0-0-1, other = random.
    int ready_mode = 0;
    int ready_phase = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.i_byte_ready = 1'b1;
            1:       bus.i_byte_ready = (ready_phase % 4 == 0) || (ready_phase % 4 == 3);
            default: bus.i_byte_ready = 1'($urandom_range(0, 1));
        endcase
        ready_phase++;
    end

    // Monitor: records accepted bytes, counts done pulses, checks stall stability.
    logic [7:0] rx_q [$];
    int         done_cnt;
    logic       prev_stall;
    logic [7:0] prev_byte;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && bus.o_byte_valid)
                check("stall_byte_stable", bus.o_byte, prev_byte);
            if (bus.o_byte_valid && bus.i_byte_ready && !i_abort)
                rx_q.push_back(bus.o_byte);
            if (o_done)
                done_cnt++;
            prev_stall = bus.o_byte_valid && !bus.i_byte_ready && !i_abort;
            prev_byte  = bus.o_byte;
        end
    end

    // Reference: the dump is every register, MSB byte first, in address order.
    function automatic logic [7:0] exp_byte(input int k);
        int r;
        int b;
        r = k / BPR;
        b = k % BPR;
        return 8'(bank[r] >> (8 * (BPR - 1 - b)));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string name);
        int mism;
        check({name, "_byte_count"}, rx_q.size(), TOTAL);
        mism = 0;
        for (int k = 0; k < TOTAL; k++)
            if (k >= rx_q.size() || rx_q[k] !== exp_byte(k)) mism++;
        check({name, "_bytes_mismatched"}, mism, 0);
    endtask

    // Full dump; returns cycles from leaving IDLE to entering DONE.
    task automatic run_dump(input string name, input int mode, input int restart_at, output int lat);
        int n;
        ready_mode = mode;
        rx_q.delete();
        done_cnt = 0;
        i_halted = 1'b1;
        i_start  = 1'b1;
        tick();
        i_start = 1'b0;
        n = 1;
        while (!o_done && n < 5000) begin
            if (mode == 2) i_halted = 1'($urandom_range(0, 1));
            i_start = (n == restart_at);
            tick();
            n++;
        end
        i_start  = 1'b0;
        i_halted = 1'b1;
        check({name, "_done_reached"}, o_done, 1'b1);
        lat = n - 1;
        tick();
        tick();
        check({name, "_done_pulses"}, done_cnt, 1);
    endtask

    typedef struct {
        string      name;
        logic       start;
        logic       abort;
        logic       halted;
        logic       exp_busy;
        logic       exp_err;
        logic       exp_valid;
        logic [4:0] exp_dir;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int         lat;
        int         n;
        int         err_cnt;
        int         busy_cnt;
        logic [63:0] first8;

        n_tests  = 0;
        n_fail   = 0;
        done_cnt = 0;
        rst      = 1'b1;
        i_start  = 1'b0;
        i_abort  = 1'b0;
        i_halted = 1'b1;
        for (int i = 0; i < NUM; i++) bank[i] = 32'h0101_0101 * i;

        vecs[0] = '{"idle_noop",        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
        vecs[1] = '{"start_halted",     1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0};
        vecs[2] = '{"start_not_halted", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0};
        vecs[3] = '{"abort_beats_start",1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
        vecs[4] = '{"abort_only",       1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};

        // Reset holds everything at zero, even with a start request present.
        repeat (2) tick();
        i_start = 1'b1;
        tick();
        check("reset_outputs", {bus.o_rd_dir, bus.o_byte, bus.o_byte_valid, o_busy, o_done, o_err}, '0);
        i_start = 1'b0;
        rst = 1'b0;
        tick();
        check("idle_after_reset", {o_busy, bus.o_byte_valid}, 2'b00);

        // Table: one cycle of inputs from IDLE, then outputs after that edge.
        for (int v = 0; v < 5; v++) begin
            i_start  = vecs[v].start;
            i_abort  = vecs[v].abort;
            i_halted = vecs[v].halted;
            tick();
            i_start  = 1'b0;
            i_abort  = 1'b0;
            i_halted = 1'b1;
            check({"vec_", vecs[v].name},
                  {o_busy, o_err, bus.o_byte_valid, bus.o_rd_dir},
                  {vecs[v].exp_busy, vecs[v].exp_err, vecs[v].exp_valid, vecs[v].exp_dir});
            i_abort = 1'b1;
            tick();
            i_abort = 1'b0;
            tick();
            check({"vec_recover_", vecs[v].name}, {o_busy, o_err}, 2'b00);
        end

        // Ramp data, ready always high: order, first bytes, latency.
        run_dump("ramp", 0, -1, lat);
        check("ramp_latency", lat, LAT);
        first8 = '0;
        for (int k = 0; k < 8; k++)
            first8 = {first8[55:0], (k < rx_q.size()) ? rx_q[k] : 8'hxx};
        check("ramp_first8", first8, 64'h0000_0000_0101_0101);
        check_stream("ramp");

        // Start while not halted: single error pulse, nothing sent.
        rx_q.delete();
        i_halted = 1'b0;
        i_start  = 1'b1;
        tick();
        i_start = 1'b0;
        err_cnt  = 0;
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            err_cnt  += int'(o_err);
            busy_cnt += int'(o_busy);
            tick();
        end
        i_halted = 1'b1;
        check("unhalted_err_pulses", err_cnt, 1);
        check("unhalted_busy_cycles", busy_cnt, 0);
        check("unhalted_bytes_sent", rx_q.size(), 0);

        // Backpressure 1-0-0-1 with a recognisable register 5.
        bank[5] = 32'hDEAD_BEEF;
        run_dump("stall", 1, -1, lat);
        check("stall_reg5_bytes",
              (rx_q.size() >= 24) ? {rx_q[20], rx_q[21], rx_q[22], rx_q[23]} : 32'hx,
              32'hDEAD_BEEF);
        check_stream("stall");

        // Second start mid-dump is ignored.
        run_dump("restart", 0, 50, lat);
        check("restart_latency", lat, LAT);
        check_stream("restart");

        // Abort while register 3 byte 2 is on the bus.
        bank[0] = 32'hDEAD_BEEF;
        ready_mode = 0;
        rx_q.delete();
        done_cnt = 0;
        i_start  = 1'b1;
        tick();
        i_start = 1'b0;
        n = 0;
        while (rx_q.size() < 3 * BPR + 2 && n < 1000) begin
            tick();
            n++;
        end
        check("abort_reach_reg3_byte2", rx_q.size(), 3 * BPR + 2);
        check("abort_presented", {bus.o_byte_valid, bus.o_rd_dir, bus.o_byte}, {1'b1, 5'd3, exp_byte(3 * BPR + 2)});
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("abort_next_cycle", {bus.o_byte_valid, o_busy, o_done}, 3'b000);
        repeat (5) tick();
        check("abort_no_extra_bytes", rx_q.size(), 3 * BPR + 2);
        check("abort_no_done", done_cnt, 0);
        run_dump("after_abort", 0, -1, lat);
        check("after_abort_first_byte", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'hDE);
        check_stream("after_abort");

        // Asynchronous reset in the middle of SEND.
        ready_mode = 0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n = 0;
        while (!(bus.o_byte_valid && bus.o_rd_dir == 5'd2) && n < 1000) begin
            tick();
            n++;
        end
        check("rst_reach_send", {bus.o_byte_valid, bus.o_rd_dir}, {1'b1, 5'd2});
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_outputs", {bus.o_rd_dir, bus.o_byte, bus.o_byte_valid, o_busy, o_done, o_err}, '0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_release_idle", {o_busy, bus.o_byte_valid, o_done}, 3'b000);
        run_dump("after_rst", 0, -1, lat);
        check("after_rst_latency", lat, LAT);
        check_stream("after_rst");

        // Randomized data, ready and halted wiggle.
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < NUM; i++) bank[i] = $urandom;
            run_dump($sformatf("rand%0d", t), 2, -1, lat);
            check_stream($sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
